// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line instruction cache responder; misses fill over a byte-wide memory port.
// Define ICACHE_STATS_EN to add the hit_count/miss_count statistics outputs.
module icache_responder #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_BITS  = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic [31:0] addr,
  input  logic        rn,
  output logic [31:0] Inst,
  output logic        Read_ready,
  output logic        mem_req,
  input  logic        mem_grant,
  output logic [31:0] mem_a,
  input  logic [7:0]  mem_din
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, WAIT_GRANT, FILL, RESPOND} state_t;

  state_t state_q, state_d;

  logic [31:0]         data_mem [LINES];
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [LINES-1:0]    valid_q;

  logic [29:0]         req_base;
  logic [2:0]          cnt;
  logic [23:0]         fill_buf;

  logic [INDEX_BITS-1:0] lk_idx, fill_idx;
  logic [TAG_BITS-1:0]   lk_tag, fill_tag;
  logic [31:0]           fill_word;
  logic                  hit;
  logic                  hit_acc, miss_acc, grant_acc, fill_step, fill_done;
  logic                  unused_addr_bits;

  assign lk_idx    = addr[INDEX_BITS+1:2];
  assign lk_tag    = addr[ADDR_BITS-1:INDEX_BITS+2];
  assign fill_idx  = req_base[INDEX_BITS-1:0];
  assign fill_tag  = req_base[ADDR_BITS-3:INDEX_BITS];
  assign fill_word = {mem_din, fill_buf};
  assign hit       = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign fill_done = fill_step && (cnt == 3'd4);

  // Byte offset and the bits above the significant address range never reach the lookup.
  assign unused_addr_bits = ^{addr[31:ADDR_BITS], addr[1:0]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (rdy) begin
      if (clr) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE:       if (rn && !hit) state_d = WAIT_GRANT;
          WAIT_GRANT: if (mem_grant) state_d = FILL;
          FILL:       if (cnt == 3'd4) state_d = RESPOND;
          RESPOND:    state_d = IDLE;
          default:    state_d = IDLE;
        endcase
      end
    end
  end

  // Decoded actions; a low rdy or a flush suppresses all of them.
  always_comb begin
    hit_acc   = 1'b0;
    miss_acc  = 1'b0;
    grant_acc = 1'b0;
    fill_step = 1'b0;
    if (rdy && !clr) begin
      case (state_q)
        IDLE: begin
          hit_acc  = rn && hit;
          miss_acc = rn && !hit;
        end
        WAIT_GRANT: grant_acc = mem_grant;
        FILL:       fill_step = 1'b1;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Inst       <= '0;
      Read_ready <= 1'b0;
      mem_req    <= 1'b0;
      mem_a      <= '0;
      valid_q    <= '0;
      req_base   <= '0;
      cnt        <= '0;
      fill_buf   <= '0;
    end else if (rdy) begin
      Read_ready <= 1'b0;
      if (clr) mem_req <= 1'b0;
      if (hit_acc) begin
        Read_ready <= 1'b1;
        Inst       <= data_mem[lk_idx];
      end
      if (miss_acc) begin
        req_base <= addr[31:2];
        mem_req  <= 1'b1;
      end
      if (grant_acc) begin
        mem_a <= {req_base, 2'b00};
        cnt   <= '0;
      end
      if (fill_step) begin
        cnt <= cnt + 3'd1;
        if (cnt < 3'd3) mem_a <= mem_a + 32'd1;
        // Byte k shows up while byte k+1 is being addressed.
        case (cnt)
          3'd1:    fill_buf[7:0]   <= mem_din;
          3'd2:    fill_buf[15:8]  <= mem_din;
          3'd3:    fill_buf[23:16] <= mem_din;
          default: ;
        endcase
      end
      if (fill_done) begin
        valid_q[fill_idx] <= 1'b1;
        mem_req           <= 1'b0;
        Read_ready        <= 1'b1;
        Inst              <= fill_word;
      end
    end
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether their contents count.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_mem[fill_idx] <= fill_word;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_acc)  hit_count  <= hit_count + 32'd1;
      if (miss_acc) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: byte memory model, delayed-grant arbiter, expected-word scoreboard.
module tb_icache_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        clr = 1'b0;
  logic        rn  = 1'b0;
  logic [31:0] addr = '0;
  logic        mem_grant = 1'b0;
  logic [7:0]  mem_din = '0;
  logic [31:0] Inst;
  logic        Read_ready;
  logic        mem_req;
  logic [31:0] mem_a;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q  [$];
  logic [31:0] seen_a [$];
  logic [7:0]  mem_model [0:4095];
  logic [31:0] a_lat = '0;
  int          gnt_delay = 2;
  int          gnt_wait  = 0;

  always #5 clk = ~clk;

  icache_responder #(.INDEX_BITS(6), .ADDR_BITS(18)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .clr        (clr),
    .addr       (addr),
    .rn         (rn),
    .Inst       (Inst),
    .Read_ready (Read_ready),
    .mem_req    (mem_req),
    .mem_grant  (mem_grant),
    .mem_a      (mem_a),
    .mem_din    (mem_din)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // Synchronous byte memory, frozen together with the rest of the system when rdy is low.
  always @(negedge clk) a_lat = mem_a;
  always @(posedge clk) if (rdy) mem_din <= mem_model[a_lat[11:0]];

  // Arbiter: grants after gnt_delay cycles of request, holds grant until the request drops.
  always @(posedge clk) begin
    if (!mem_req) begin
      mem_grant <= 1'b0;
      gnt_wait  <= 0;
    end else if (!mem_grant) begin
      if (gnt_wait >= gnt_delay) mem_grant <= 1'b1;
      else                       gnt_wait  <= gnt_wait + 1;
    end
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [11:0] b;
    b = a[11:0];
    return {mem_model[b + 12'd3], mem_model[b + 12'd2], mem_model[b + 12'd1], mem_model[b]};
  endfunction

  // One fetch: push the expected word, wait (bounded) for Read_ready, pop and compare.
  task automatic fetch(input logic [31:0] a, input logic [31:0] exp_inst, input int exp_lat,
                       input int stall_at, input string name);
    int          lat;
    logic [31:0] prev_a, frozen_a, exp_w;
    bit          saw_req;
    exp_q.push_back(exp_inst);
    seen_a.delete();
    prev_a   = mem_a;
    frozen_a = '0;
    saw_req  = 1'b0;
    lat      = 0;
    addr     = a;
    rn       = 1'b1;
    do begin
      @(posedge clk); #1;
      rn = 1'b0;
      lat++;
      if (mem_req) saw_req = 1'b1;
      if (mem_req && mem_a !== prev_a) begin
        seen_a.push_back(mem_a);
        prev_a = mem_a;
      end
      if (stall_at > 0) begin
        if (lat == stall_at) begin
          frozen_a = mem_a;
          rdy      = 1'b0;
        end else if (lat > stall_at && lat <= stall_at + 3) begin
          checks++;
          if (mem_a !== frozen_a) begin
            errors++;
            $display("FAIL %s_frozen_mem_a: got %h expected %h", name, mem_a, frozen_a);
          end
          if (lat == stall_at + 3) rdy = 1'b1;
        end
      end
    end while (Read_ready !== 1'b1 && lat < 200);
    rdy = 1'b1;
    exp_w = exp_q.pop_front();
    checks++;
    if (Read_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: no Read_ready within %0d cycles", name, lat);
    end else begin
      checks++;
      if (Inst !== exp_w) begin
        errors++;
        $display("FAIL %s_inst: got %h expected %h", name, Inst, exp_w);
      end
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
      end
      checks++;
      if (saw_req != (exp_lat != 1)) begin
        errors++;
        $display("FAIL %s_mem_req_seen: got %0b expected %0b", name, saw_req, exp_lat != 1);
      end
      @(posedge clk); #1;
      checks++;
      if (Read_ready !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL %s_after: Read_ready %b mem_req %b expected 0 0", name, Read_ready, mem_req);
      end
    end
  endtask

  task automatic check_fill_addrs(input logic [31:0] base, input string name);
    checks++;
    if (seen_a.size() != 4) begin
      errors++;
      $display("FAIL %s_addr_count: got %0d expected 4", name, seen_a.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (seen_a[k] !== base + 32'(k)) begin
          errors++;
          $display("FAIL %s_mem_a%0d: got %h expected %h", name, k, seen_a[k], base + 32'(k));
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (Inst !== 32'h0 || Read_ready !== 1'b0 || mem_req !== 1'b0 || mem_a !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: Inst %h Read_ready %b mem_req %b mem_a %h expected all 0",
               Inst, Read_ready, mem_req, mem_a);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_cold_miss();
    fetch(32'h10, 32'h9300_0013, 10, 0, "cold_miss");
    check_fill_addrs(32'h10, "cold_miss");
  endtask

  task automatic test_hit();
    fetch(32'h10, 32'h9300_0013, 1, 0, "hit");
    fetch(32'hFFFC_0010, 32'h9300_0013, 1, 0, "hit_upper_ignored");
  endtask

  task automatic test_eviction();
    fetch(32'h110, 32'hDEAD_BEEF, 10, 0, "evict_fill");
    check_fill_addrs(32'h110, "evict_fill");
    fetch(32'h10, 32'h9300_0013, 10, 0, "evict_refill");
    fetch(32'h10, 32'h9300_0013, 1, 0, "evict_rehit");
  endtask

  task automatic test_flush();
    int n;
    int pulses;
    addr = 32'h20;
    rn   = 1'b1;
    n    = 0;
    do begin
      @(posedge clk); #1;
      rn = 1'b0;
      n++;
    end while (!(mem_req === 1'b1 && mem_a === 32'h22) && n < 100);
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL flush_reach_byte2: mem_a %h never reached 00000022", mem_a);
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || Read_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: mem_req %b Read_ready %b expected 0 0", mem_req, Read_ready);
    end
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (Read_ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL flush_no_ready: got %0d pulses expected 0", pulses);
    end
    fetch(32'h20, word_at(32'h20), 10, 0, "flush_refill");
  endtask

  task automatic test_clr_with_rn(input logic [31:0] a, input string name);
    int pulses;
    int reqs;
    addr = a;
    rn   = 1'b1;
    clr  = 1'b1;
    pulses = 0;
    reqs   = 0;
    repeat (4) begin
      @(posedge clk); #1;
      rn  = 1'b0;
      clr = 1'b0;
      if (Read_ready === 1'b1) pulses++;
      if (mem_req === 1'b1) reqs++;
    end
    checks++;
    if (pulses != 0 || reqs != 0) begin
      errors++;
      $display("FAIL %s: Read_ready cycles %0d mem_req cycles %0d expected 0 0", name, pulses, reqs);
    end
  endtask

  task automatic test_stall();
    fetch(32'h30, word_at(32'h30), 13, 6, "stall");
    check_fill_addrs(32'h30, "stall");
  endtask

  task automatic test_async_reset();
    int n;
    addr = 32'h40;
    rn   = 1'b1;
    n    = 0;
    do begin
      @(posedge clk); #1;
      rn = 1'b0;
      n++;
    end while (!(mem_req === 1'b1 && mem_a === 32'h41) && n < 100);
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL rst_reach_fill: mem_a %h never reached 00000041", mem_a);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (Inst !== 32'h0 || Read_ready !== 1'b0 || mem_req !== 1'b0 || mem_a !== 32'h0) begin
      errors++;
      $display("FAIL rst_async: Inst %h Read_ready %b mem_req %b mem_a %h expected all 0",
               Inst, Read_ready, mem_req, mem_a);
    end
`ifdef ICACHE_STATS_EN
    checks++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      errors++;
      $display("FAIL rst_counters: hits %0d misses %0d expected 0 0", hit_count, miss_count);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    fetch(32'h20, word_at(32'h20), 10, 0, "rst_then_miss");
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    logic [31:0] h0, m0;
    h0 = hit_count;
    m0 = miss_count;
    fetch(32'h50, word_at(32'h50), 10, 0, "stats_miss");
    fetch(32'h50, word_at(32'h50), 1, 0, "stats_hit1");
    fetch(32'h50, word_at(32'h50), 1, 0, "stats_hit2");
    addr = 32'h60;
    rn   = 1'b1;
    @(posedge clk); #1;
    rn  = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (hit_count - h0 !== 32'd2 || miss_count - m0 !== 32'd2) begin
      errors++;
      $display("FAIL stats_counts: hits %0d misses %0d expected 2 2", hit_count - h0, miss_count - m0);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem_model[i] = 8'(i) ^ 8'h5A;
    mem_model[12'h010] = 8'h13;
    mem_model[12'h011] = 8'h00;
    mem_model[12'h012] = 8'h00;
    mem_model[12'h013] = 8'h93;
    mem_model[12'h110] = 8'hEF;
    mem_model[12'h111] = 8'hBE;
    mem_model[12'h112] = 8'hAD;
    mem_model[12'h113] = 8'hDE;
    mem_model[12'h020] = 8'h11;
    mem_model[12'h021] = 8'h22;
    mem_model[12'h022] = 8'h33;
    mem_model[12'h023] = 8'h44;

    test_reset();
    test_cold_miss();
    test_hit();
    test_eviction();
    test_flush();
    test_clr_with_rn(32'h10, "clr_rn_hit");
    test_clr_with_rn(32'h70, "clr_rn_miss");
    test_stall();
    test_async_reset();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-cache responder on the fetch interface: accepts fetch requests (addr, rn) and returns a 32-bit instruction with a one-cycle Read_ready pulse.
- Direct-mapped, one word per line.
- On a miss, fills the line over the shared byte-wide memory port after arbitration (mem_req/mem_grant).
- Sits between the fetch stage and the memory controller.

Parameters:
INDEX_BITS, 6, log2 of line count (64 lines × 1 word)
ADDR_BITS, 18, significant address bits; addr[31:ADDR_BITS] ignored

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
rdy  input  1  global ready; all state frozen when low
clr  input  1  flow-control flush; aborts pending request
addr  input  32  fetch address; word-aligned, bits [1:0] ignored
rn  input  1  read request; sampled in IDLE only
Inst  output  32  instruction word; valid when Read_ready
Read_ready  output  1  one-cycle pulse, Inst valid
mem_req  output  1  memory-port request to arbiter
mem_grant  input  1  arbiter grant; held by arbiter while mem_req high
mem_a  output  32  byte address to memory
mem_din  input  8  memory read data; valid one cycle after mem_a

Behaviour:
- Reset (async, rst=1): Inst=0, Read_ready=0, mem_req=0, mem_a=0, all valid bits cleared, state=IDLE.
- Address split:
  - index = addr[INDEX_BITS+1:2]
  - tag = addr[ADDR_BITS-1:INDEX_BITS+2]
  - captured into req_addr when a request is accepted.
- rdy=0: no register changes, including Read_ready. Resumes exactly where it stopped.
- States: IDLE, WAIT_GRANT, FILL, RESPOND.
- IDLE:
  - rn=1 and hit: next cycle Read_ready=1 and Inst=line data. One-cycle latency; state stays IDLE.
  - rn=1 and miss: capture addr, mem_req=1, go to WAIT_GRANT.
- WAIT_GRANT: on mem_grant=1, set mem_a=req_addr&~3, byte counter=0, go to FILL.
- FILL:
  - Issues byte addresses base+0..base+3, one per cycle.
  - Byte k arrives on mem_din the cycle after its address and lands in word bits [8k+7:8k] (little-endian).
  - 5 cycles in FILL: 4 issue cycles plus 1 trailing data cycle.
  - After byte 3: write data and tag, set valid, drop mem_req, go to RESPOND.
- RESPOND: Read_ready=1, Inst=filled word for one cycle, return to IDLE.
- Read_ready is high for exactly one cycle per accepted request; 0 in all other cycles.
- Miss latency from request cycle: 1 (IDLE→WAIT_GRANT) + grant wait + 5 (FILL) + 1 (RESPOND output).
- rn while not IDLE: ignored. The fetcher holds no new request until Read_ready.
- clr, any state:
  - Return to IDLE next cycle; drop mem_req; suppress any pending Read_ready.
  - A partially filled line is not written; valid is unchanged.
  - A hit result pending for the next cycle is suppressed.
  - clr and rn in the same IDLE cycle: clr wins, request not accepted.
- mem_grant deasserted mid-FILL: protocol violation, undefined. Arbiter holds grant until mem_req drops.
- Tag/data arrays are plain registers. Only valid bits are reset; the data array is not.

Optional Feature:
ICACHE_STATS_EN
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], reset 0.
  - hit_count increments per IDLE hit accepted; miss_count per miss accepted.
  - Both counters wrap at 2^32.
  - Counting is unaffected by a later clr abort, and counters do not change while rdy=0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Cold miss: reset, rn=1, addr=0x0000_0010; mem bytes at 0x10..0x13 = 13,00,00,93; grant after 2 cycles → mem_a steps 0x10,0x11,0x12,0x13; then Read_ready pulse with Inst=0x9300_0013; mem_req low afterwards.
- Hit: repeat addr=0x10 → Read_ready next cycle, Inst=0x9300_0013, mem_req stays 0.
- Conflict eviction: fill 0x10, then request 0x110 (same index 4 at INDEX_BITS=6, different tag) → miss and refill; a subsequent 0x10 request misses again.
- Flush mid-fill: miss on 0x20, clr after byte 1 → mem_req drops next cycle, no Read_ready; later request to 0x20 still misses and fills correctly.
- Stall: rdy=0 for 3 cycles during FILL → mem_a and byte counter frozen, Read_ready delayed by exactly 3 cycles; Inst correct. Async rst mid-fill → all outputs 0 immediately, 0x20 misses afterwards.
- Stats (ICACHE_STATS_EN): sequence miss, hit, hit, clr-aborted miss → hit_count=2, miss_count=2.
